// File: rtl/uart_defs_pkg.sv
// uart_defs: shared constants and state encodings for the fruit-result UART receiver
package uart_defs;
  localparam logic [7:0] PKT_HDR = 8'hAA;
  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [1:0] P_HDR   = 2'd0;
  localparam logic [1:0] P_CLASS = 2'd1;
  localparam logic [1:0] P_CHK   = 2'd2;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-FF synchronizer plus 8N1 byte receiver with half-bit start validation
module uart_rx_byte
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  logic [1:0]    sync;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  assign rx_s = sync[1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      state     <= S_WAIT_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], uart_rx};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      cnt       <= cnt + 1'b1;
      case (state)
        // the synchronizer still holds its reset ones for two cycles, so wait for it to flush
        S_WAIT_IDLE: if (rx_s && cnt > CW'(1)) begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        S_IDLE: if (!rx_s) begin
          state <= S_START;
          cnt   <= '0;
        end
        S_START: if (cnt == HALF_LAST) begin
          state   <= rx_s ? S_IDLE : S_DATA;
          cnt     <= '0;
          bit_idx <= '0;
        end
        S_DATA: if (cnt == BIT_LAST) begin
          shreg   <= {rx_s, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
          cnt     <= '0;
          if (bit_idx == 3'd7) state <= S_STOP;
        end
        S_STOP: if (cnt == BIT_LAST) begin
          cnt       <= '0;
          state     <= rx_s ? S_IDLE : S_WAIT_IDLE;
          rx_valid  <= rx_s;
          frame_err <= !rx_s;
          if (rx_s) rx_data <= shreg;
        end
        default: begin
          state <= S_WAIT_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/uart_result_rx.sv
// uart_result_rx: UART receiver plus header/class/checksum packet decoder with inter-byte timeout
module uart_result_rx
  import uart_defs::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [7:0] fruit_id,
  output logic       fruit_valid,
  output logic       pkt_err
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO);
  // counter restarts the cycle after the clearing strobe, so this lands pkt_err exactly TO cycles later
  localparam logic [TW-1:0] TO_LAST = TW'(TO - 2);
  logic [1:0]    pst;
  logic [7:0]    cand;
  logic [TW-1:0] tcnt;
  logic          hit;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );
  assign hit = rx_data == (cand ^ PKT_HDR);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pst         <= P_HDR;
      cand        <= '0;
      fruit_id    <= '0;
      fruit_valid <= 1'b0;
      pkt_err     <= 1'b0;
      tcnt        <= '0;
    end else begin
      fruit_valid <= 1'b0;
      pkt_err     <= 1'b0;
      tcnt        <= tcnt + 1'b1;
      if (rx_valid) begin
        tcnt <= '0;
        pst  <= (pst == P_HDR) ? ((rx_data == PKT_HDR) ? P_CLASS : P_HDR)
              : (pst == P_CLASS) ? P_CHK : P_HDR;
        if (pst == P_CLASS) cand <= rx_data;
        if (pst == P_CHK) begin
          fruit_valid <= hit;
          pkt_err     <= !hit;
          if (hit) fruit_id <= cand;
        end
      end else if (pst != P_HDR && (frame_err || tcnt == TO_LAST)) begin
        pkt_err <= 1'b1;
        pst     <= P_HDR;
        tcnt    <= '0;
      end else if (pst == P_HDR) begin
        tcnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_result_rx.sv
// tb_uart_result_rx: directed serial stimulus with a scoreboard queue checked by an independent strobe monitor
module tb_uart_result_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [7:0] fruit_id;
  logic       fruit_valid;
  logic       pkt_err;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_ref = 0;
  int last_cyc = 0;
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         dly;
    bit         use_ref;
  } exp_t;
  exp_t q[$];
  uart_result_rx #(.CLK_FREQ(1_843_200), .BAUD(115200), .TIMEOUT_BITS(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .fruit_id    (fruit_id),
    .fruit_valid (fruit_valid),
    .pkt_err     (pkt_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic expect_evt(input int k, input logic [7:0] d, input int dly);
    q.push_back('{k, d, dly, 1'b0});
  endtask
  task automatic check_evt(input int k, input logic [7:0] d);
    exp_t e;
    bit ok;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected strobe kind=%0d data=%h at cycle %0d, none required", k, d, cyc);
    end else begin
      e = q.pop_front();
      ok = (e.kind == k) && (e.data == d);
      if (e.use_ref) ok = ok && ((cyc - t_ref == e.dly) || (cyc - t_ref == e.dly + 1));
      else if (e.dly >= 0) ok = ok && (cyc - last_cyc == e.dly);
      if (!ok) begin
        errors++;
        $display("FAIL strobe got kind=%0d data=%h gap=%0d/%0d, required kind=%0d data=%h delay=%0d",
                 k, d, cyc - last_cyc, cyc - t_ref, e.kind, e.data, e.dly);
      end
    end
    last_cyc = cyc;
  endtask
  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(16);
    end
    uart_rx = stop;
    idle(16);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rx_valid) check_evt(0, rx_data);
      if (frame_err) check_evt(1, rx_data);
      if (fruit_valid) check_evt(2, fruit_id);
      if (pkt_err) check_evt(3, fruit_id);
    end
  end
  initial begin
    idle(5);
    check_val("reset rx_data", rx_data, 8'h00);
    check_val("reset fruit_id", fruit_id, 8'h00);
    check_val("reset strobes", {4'h0, rx_valid, frame_err, fruit_valid, pkt_err}, 8'h00);
    rst_n = 1'b1;
    idle(20);
    q.push_back('{0, 8'h5A, 155, 1'b1});
    expect_evt(0, 8'hFF, 160);
    t_ref = cyc;
    send(8'h5A, 1'b1);
    send(8'hFF, 1'b1);
    idle(20);
    expect_evt(0, 8'hAA, -1);
    expect_evt(0, 8'h03, 160);
    expect_evt(0, 8'hA9, 160);
    expect_evt(2, 8'h03, 1);
    send(8'hAA, 1'b1);
    send(8'h03, 1'b1);
    send(8'hA9, 1'b1);
    idle(20);
    expect_evt(0, 8'hAA, -1);
    expect_evt(0, 8'h03, 160);
    expect_evt(0, 8'h00, 160);
    expect_evt(3, 8'h03, 1);
    send(8'hAA, 1'b1);
    send(8'h03, 1'b1);
    send(8'h00, 1'b1);
    idle(20);
    expect_evt(0, 8'hAA, -1);
    expect_evt(1, 8'hAA, 160);
    expect_evt(3, 8'h03, 1);
    send(8'hAA, 1'b1);
    send(8'h03, 1'b0);
    uart_rx = 1'b1;
    idle(20);
    expect_evt(0, 8'hAA, -1);
    expect_evt(0, 8'h07, 160);
    expect_evt(0, 8'hAD, 160);
    expect_evt(2, 8'h07, 1);
    send(8'hAA, 1'b1);
    send(8'h07, 1'b1);
    send(8'hAD, 1'b1);
    idle(20);
    expect_evt(0, 8'hAA, -1);
    expect_evt(3, 8'h07, 320);
    send(8'hAA, 1'b1);
    idle(340);
    expect_evt(0, 8'h11, -1);
    expect_evt(0, 8'h22, 160);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    idle(20);
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(40);
    uart_rx = 1'b0;
    idle(30);
    rst_n = 1'b0;
    idle(5);
    rst_n = 1'b1;
    idle(50);
    check_val("post-reset rx_data", rx_data, 8'h00);
    check_val("post-reset fruit_id", fruit_id, 8'h00);
    uart_rx = 1'b1;
    idle(20);
    expect_evt(0, 8'h3C, -1);
    send(8'h3C, 1'b1);
    idle(50);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending strobes got %0d outstanding required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
